// File: rtl/seri_bcd_toplayici.sv
// seri_bcd_toplayici: digit-serial packed-BCD adder.
// Operands are captured on an accepted start, then one BCD digit pair is
// added per clock from the least significant digit upward. The partial sum
// is visible while busy; sum, c_out and err hold after the done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; last result held on sum/c_out/err
// S_ADD  | adding digit idx_q of the captured operands (busy=1)
// S_DONE | one-cycle result-final indication (done=1), start ignored
module seri_bcd_toplayici #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [3:0]         a_dig;
  logic [3:0]         b_dig;
  logic [4:0]         raw;
  logic [3:0]         dig;
  logic               dig_carry;
  logic               dig_bad;
  logic               last_dig;

  // Select the current digit pair and apply the decimal-adjust rule.
  // raw can reach 31 (invalid digits plus carry); the +6 wraps mod 16.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    raw       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    dig_carry = (raw > 5'd9);
    dig       = dig_carry ? (raw[3:0] + 4'd6) : raw[3:0];
    dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
    last_dig  = (idx_q == IDX_W'(DIGITS - 1));
  end

  // Next-state and next-output computation; busy/done follow the next state
  // so that they come out of flops aligned with the state register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_ADD;
          busy_d  = 1'b1;
        end
      end

      S_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[4*i +: 4] = dig;
          end
        end
        carry_d = dig_carry;
        err_d   = err_q | dig_bad;
        if (last_dig) begin
          c_out_d = dig_carry;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seri_bcd_toplayici.sv
// Bench for seri_bcd_toplayici (DIGITS=4): a timeline model of the serial
// BCD add checked every cycle, plus literal results for directed operations.
module tb_seri_bcd_toplayici;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          c_in  = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          err;

  seri_bcd_toplayici #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One decimal digit step: {carry, digit} from two digits and a carry in.
  function automatic logic [4:0] bcd_step(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int r;
    r = int'(x) + int'(y) + int'(ci);
    if (r > 9) return {1'b1, 4'((r + 6) % 16)};
    return {1'b0, 4'(r)};
  endfunction

  // Model: m_since counts edges since the capture edge (-1 when idle).
  int           m_since = -1;
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_b     = '0;
  logic [W-1:0] m_sum   = '0;
  logic         m_carry = 1'b0;
  logic         m_cout  = 1'b0;
  logic         m_err   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int          i;
    logic [3:0]  da, db;
    logic [4:0]  r;
    if (!rst_n) begin
      m_since = -1;
      m_a = '0; m_b = '0; m_sum = '0;
      m_carry = 1'b0; m_cout = 1'b0; m_err = 1'b0;
    end else if (m_since < 0) begin
      if (start === 1'b1) begin
        m_a = a; m_b = b; m_carry = c_in;
        m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (m_since <= DIGITS) begin
        i  = m_since - 1;
        da = m_a[4*i +: 4];
        db = m_b[4*i +: 4];
        r  = bcd_step(da, db, m_carry);
        m_sum[4*i +: 4] = r[3:0];
        m_carry = r[4];
        if (da > 4'd9 || db > 4'd9) m_err = 1'b1;
        if (m_since == DIGITS) m_cout = r[4];
      end else begin
        m_since = -1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  32'(busy),  32'(m_since >= 0 && m_since < DIGITS));
      chk("cyc_done",  32'(done),  32'(m_since == DIGITS));
      chk("cyc_sum",   32'(sum),   32'(m_sum));
      chk("cyc_c_out", 32'(c_out), 32'(m_cout));
      chk("cyc_err",   32'(err),   32'(m_err));
      chk("cyc_busy_and_done", 32'(busy & done), 32'd0);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic ee, input string tag);
    int busy_n;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; c_in = ~tc;
    chk({tag, "_busy_first"}, 32'(busy), 32'd1);
    chk({tag, "_err_cleared"}, 32'(err), 32'd0);
    busy_n = 1;
    for (int n = 0; n < 20 && done !== 1'b1; n++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(DIGITS));
    chk({tag, "_sum"},   32'(sum),   32'(es));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    chk({tag, "_err"},   32'(err),   32'(ee));
    @(negedge clk);
    chk({tag, "_hold_sum"},  32'(sum),  32'(es));
    chk({tag, "_done_low"},  32'(done), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "add_1234_5678");
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_9999_0001");
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, "max_valid_cin");
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "zero_cin");
    run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, "invalid_digit");
    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "err_clear");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1, "worst_raw");
    run_op(16'h0458, 16'h0367, 1'b0, 16'h0825, 1'b0, 1'b0, "mixed_carry");

    // start held with changing operands through the operation
    d0 = done_cnt;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; c_in = 1'b0; start = 1'b1;
    repeat (DIGITS) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); c_in = 1'b1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("restart_done",  32'(done),  32'd1);
    chk("restart_sum",   32'(sum),   32'h6912);
    chk("restart_c_out", 32'(c_out), 32'd0);
    repeat (4) @(negedge clk);
    chk("restart_one_done", 32'(done_cnt - d0), 32'd1);
    chk("restart_hold_sum", 32'(sum), 32'h6912);

    // reset in the middle of an operation
    d0 = done_cnt;
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_partial_sum", 32'(sum), 32'h0032);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_done",  32'(done),  32'd0);
    chk("mid_rst_sum",   32'(sum),   32'd0);
    chk("mid_rst_c_out", 32'(c_out), 32'd0);
    chk("mid_rst_err",   32'(err),   32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, "after_reset");

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
